// File: rtl/fpu_pkg.sv
// Shared constants and types for the FP normaliser.
// Mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky.
package fpu_pkg;

  localparam int MANT_W = 28;
  localparam int RES_W  = 26;
  localparam int EXP_W  = 8;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int GUARD_BIT  = 2;
  localparam int ROUND_BIT  = 1;
  localparam int STICKY_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/fp_lzc28.sv
// 28-bit leading-zero counter with all-zero flag.
// Only compiled into the build when FP_NORM_LZC_EN is defined.
`ifdef FP_NORM_LZC_EN
module fp_lzc28 (
  input  logic [27:0] val_i,
  output logic [4:0]  cnt_o,
  output logic        zero_o
);

  // Scan upward so the highest set bit writes the count last.
  always_comb begin
    cnt_o = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (val_i[i]) cnt_o = 5'(27 - i);
    end
  end

  assign zero_o = (val_i == 28'd0);

endmodule
`endif

// File: rtl/fp_normalize.sv
// Post-add normaliser: one-bit right shift on carry, left shifts until the
// hidden bit is set or the exponent bottoms out at 1 (then flagged subnormal).
// Build option FP_NORM_LZC_EN: single-cycle LZC + barrel shift instead of
// one left shift per cycle; results are identical either way.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | normalising the captured mantissa/exponent
// DONE  | result loaded into output regs, held until out_ready
module fp_normalize
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [27:0] in_mant,
  input  logic [7:0]  in_exp,
  input  logic        in_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] result_mant,
  output logic [7:0]  result_exp,
  output logic        result_sign,
  output logic        overflow,
  output logic        norm_zero
);

  norm_state_e state_q, state_d;

  logic [MANT_W-1:0] mant_q, norm_mant;
  logic [EXP_W-1:0]  exp_q, norm_exp;
  logic              sign_q, ovf_q, zero_q;
  logic              norm_ovf, norm_zro, norm_done, mant_is_zero;
  logic [EXP_W:0]    exp_inc;
  logic              load_out;

  logic [RES_W-1:0]  res_mant_q;
  logic [EXP_W-1:0]  res_exp_q;
  logic              res_sign_q, res_ovf_q, res_zero_q, out_valid_q;

`ifdef FP_NORM_LZC_EN
  logic [4:0]        lzc_cnt;
  logic              lzc_zero;
  logic [EXP_W-1:0]  shift_need, shift_room;

  fp_lzc28 u_lzc (
    .val_i  (mant_q),
    .cnt_o  (lzc_cnt),
    .zero_o (lzc_zero)
  );

  assign mant_is_zero = lzc_zero;
`else
  assign mant_is_zero = (mant_q == '0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)                  state_d = S_NORM;
      S_NORM:  if (norm_done)                 state_d = S_DONE;
      S_DONE:  if (out_valid_q && out_ready)  state_d = S_IDLE;
      default:                                state_d = S_IDLE;
    endcase
  end

  // FSM outputs; DONE spends its first cycle loading the output registers.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    load_out = (state_q == S_DONE) && !out_valid_q;
  end

  // One normalisation step; the shift that lands the hidden bit also ends NORM.
  always_comb begin
    norm_mant = mant_q;
    norm_exp  = exp_q;
    norm_ovf  = 1'b0;
    norm_zro  = 1'b0;
    norm_done = 1'b1;
    exp_inc   = {1'b0, exp_q} + 9'd1;
`ifdef FP_NORM_LZC_EN
    shift_need = {3'b000, lzc_cnt} - 8'd1;
    shift_room = exp_q - 8'd1;
`endif
    if (mant_is_zero) begin
      norm_zro = 1'b1;
      norm_exp = '0;
    end else if (mant_q[CARRY_BIT]) begin
      if (exp_inc >= {1'b0, EXP_MAX}) begin
        norm_ovf  = 1'b1;
        norm_exp  = EXP_MAX;
        norm_mant = '0;
      end else begin
        norm_mant = {1'b0, mant_q[CARRY_BIT:ROUND_BIT+1],
                     mant_q[ROUND_BIT] | mant_q[STICKY_BIT]};
        norm_exp  = exp_inc[EXP_W-1:0];
      end
    end else if (mant_q[HIDDEN_BIT]) begin
      norm_done = 1'b1;
    end else if (exp_q <= 8'd1) begin
      norm_exp = '0;
    end else begin
`ifdef FP_NORM_LZC_EN
      // Hitting the hidden bit exactly at exp 1 is still a normal number.
      if (shift_need <= shift_room) begin
        norm_mant = mant_q << shift_need;
        norm_exp  = exp_q - shift_need;
      end else begin
        norm_mant = mant_q << shift_room;
        norm_exp  = '0;
      end
`else
      norm_mant = {mant_q[MANT_W-2:0], 1'b0};
      norm_exp  = exp_q - 8'd1;
      if (!norm_mant[HIDDEN_BIT]) begin
        if (norm_exp == 8'd1) norm_exp  = '0;
        else                  norm_done = 1'b0;
      end
`endif
    end
  end

  // Working registers: capture on accept, update every NORM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_q <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      mant_q <= in_mant;
      exp_q  <= in_exp;
      sign_q <= in_sign;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (state_q == S_NORM) begin
      mant_q <= norm_mant;
      exp_q  <= norm_exp;
      ovf_q  <= norm_ovf;
      zero_q <= norm_zro;
    end
  end

  // Output registers: loaded once in DONE, then held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_mant_q  <= '0;
      res_exp_q   <= '0;
      res_sign_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load_out) begin
      res_mant_q  <= mant_q[RES_W-1:0];
      res_exp_q   <= exp_q;
      res_sign_q  <= sign_q;
      res_ovf_q   <= ovf_q;
      res_zero_q  <= zero_q;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign result_mant = res_mant_q;
  assign result_exp  = res_exp_q;
  assign result_sign = res_sign_q;
  assign overflow    = res_ovf_q;
  assign norm_zero   = res_zero_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize: vector table driven through a scoreboard queue,
// plus backpressure and mid-operation reset sequences.
// Latency expectations follow FP_NORM_LZC_EN when it is defined.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [27:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [25:0] result_mant;
  logic [7:0]  result_exp;
  logic        result_sign, overflow, norm_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fp_normalize dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mant     (in_mant),
    .in_exp      (in_exp),
    .in_sign     (in_sign),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_mant (result_mant),
    .result_exp  (result_exp),
    .result_sign (result_sign),
    .overflow    (overflow),
    .norm_zero   (norm_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [27:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic [25:0] e_mant;
    logic [7:0]  e_exp;
    logic        e_ovf;
    logic        e_zero;
    int          k;
  } vec_t;

  typedef struct {
    logic [25:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        ovf;
    logic        zero;
    int          lat;
    int          acc;
    int          idx;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, req);
    end
  endtask

  // Compare each completed result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      check("result_mant", e.idx, 32'(result_mant), 32'(e.mant));
      check("result_exp",  e.idx, 32'(result_exp),  32'(e.exp));
      check("result_sign", e.idx, 32'(result_sign), 32'(e.sign));
      check("overflow",    e.idx, 32'(overflow),    32'(e.ovf));
      check("norm_zero",   e.idx, 32'(norm_zero),   32'(e.zero));
      check("latency",     e.idx, 32'(cyc - e.acc), 32'(e.lat));
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", idx, 32'(in_ready), 32'd1);
    in_mant  = v.mant;
    in_exp   = v.exp;
    in_sign  = v.sign;
    in_valid = 1'b1;
    e.mant = v.e_mant;
    e.exp  = v.e_exp;
    e.sign = v.sign;
    e.ovf  = v.e_ovf;
    e.zero = v.e_zero;
`ifdef FP_NORM_LZC_EN
    e.lat = 2;
`else
    e.lat = ((v.k > 1) ? v.k : 1) + 1;
`endif
    e.acc = cyc + 1;
    e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout[%0d]: no result after 100 cycles, expected one", idx);
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_in_ready"},  0, 32'(in_ready),    32'd1);
    check({name, "_out_valid"}, 0, 32'(out_valid),   32'd0);
    check({name, "_mant"},      0, 32'(result_mant), 32'd0);
    check({name, "_exp"},       0, 32'(result_exp),  32'd0);
    check({name, "_sign"},      0, 32'(result_sign), 32'd0);
    check({name, "_ovf"},       0, 32'(overflow),    32'd0);
    check({name, "_zero"},      0, 32'(norm_zero),   32'd0);
  endtask

  initial begin
    int n;
    //            mant          exp     sign  e_mant        e_exp   ovf   zero  k
    vecs[0]  = '{28'h4000000, 8'd127, 1'b0, 26'h0000000, 8'd127, 1'b0, 1'b0, 0};
    vecs[1]  = '{28'h8000003, 8'd127, 1'b1, 26'h0000001, 8'd128, 1'b0, 1'b0, 1};
    vecs[2]  = '{28'h0000008, 8'd100, 1'b0, 26'h0000000, 8'd77,  1'b0, 1'b0, 23};
    vecs[3]  = '{28'h8000000, 8'd254, 1'b1, 26'h0000000, 8'd255, 1'b1, 1'b0, 1};
    vecs[4]  = '{28'h0100000, 8'd3,   1'b0, 26'h0400000, 8'd0,   1'b0, 1'b0, 2};
    vecs[5]  = '{28'h0000000, 8'd50,  1'b1, 26'h0000000, 8'd0,   1'b0, 1'b1, 0};
    vecs[6]  = '{28'h2000005, 8'd10,  1'b0, 26'h000000A, 8'd9,   1'b0, 1'b0, 1};
    vecs[7]  = '{28'h0800001, 8'd2,   1'b1, 26'h1000002, 8'd0,   1'b0, 1'b0, 1};
    vecs[8]  = '{28'h7FFFFFF, 8'd200, 1'b0, 26'h3FFFFFF, 8'd200, 1'b0, 1'b0, 0};
    vecs[9]  = '{28'h0000001, 8'd30,  1'b1, 26'h0000000, 8'd4,   1'b0, 1'b0, 26};
    vecs[10] = '{28'h0000001, 8'd27,  1'b0, 26'h0000000, 8'd1,   1'b0, 1'b0, 26};
    vecs[11] = '{28'h8000001, 8'd253, 1'b1, 26'h0000001, 8'd254, 1'b0, 1'b0, 1};
    vecs[12] = '{28'h0400000, 8'd1,   1'b0, 26'h0400000, 8'd0,   1'b0, 1'b0, 0};

    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Backpressure: result and in_ready held while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    in_mant = 28'h8000003; in_exp = 8'd127; in_sign = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_valid_seen", 0, 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", i, 32'(out_valid),   32'd1);
      check("bp_in_ready",  i, 32'(in_ready),    32'd0);
      check("bp_mant",      i, 32'(result_mant), 32'd1);
      check("bp_exp",       i, 32'(result_exp),  32'd128);
      check("bp_sign",      i, 32'(result_sign), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_released_valid", 0, 32'(out_valid), 32'd0);
    check("bp_released_ready", 0, 32'(in_ready),  32'd1);

    // Reset in the middle of a long normalisation.
    @(negedge clk);
    in_mant = 28'h0000008; in_exp = 8'd100; in_sign = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_norm_busy", 0, 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    @(negedge clk);
    check_reset_vals("rst_next");
    rst_n = 1'b1;
    run_vec(vecs[0], 100);
    run_vec(vecs[4], 104);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_normalize.md
FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand present
- in_ready  out  1  block can accept
- in_mant  in  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
- in_exp  in  8  biased exponent of in_mant
- in_sign  in  1  result sign
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- result_mant  out  26  fraction+GRS, rounding-stage format
- result_exp  out  8  biased exponent
- result_sign  out  1  registered in_sign
- overflow  out  1  exponent reached 255
- norm_zero  out  1  in_mant was all zero

Function
REQ-002 SHALL implement a three-state FSM: IDLE, NORM, DONE.
REQ-003 IDLE: in_ready=1; on in_valid&&in_ready SHALL register mant, exp and sign, then go to NORM.
REQ-004 in_ready SHALL be 0 in NORM and DONE; there is no overlap of operations.
REQ-005 NORM, carry set (mant[27]=1): one right shift per cycle; new bit0 = mant[1]|mant[0]; exp+1; then DONE.
REQ-006 NORM, carry clear: while mant[26]=0 and exp>1, SHALL left shift by 1 (zero fill) and decrement exp by 1 each cycle.
REQ-007 SHALL leave NORM once mant[26]=1, or once exp==1 with mant[26]=0; in the latter case exp SHALL be set to 0 (subnormal) and the mantissa left unshifted further.
REQ-008 SHALL treat in_mant==0 as a single NORM cycle giving norm_zero=1, result_exp=0, result_mant=0.
REQ-009 An already-normalised input SHALL spend exactly one cycle in NORM.
REQ-010 If the exp increment in REQ-005 yields 255, SHALL set overflow=1 and result_exp=255 with result_mant=0.
REQ-011 DONE: out_valid=1 and outputs SHALL be held stable until out_ready=1; on handshake SHALL go to IDLE.
REQ-012 Iterative latency: out_valid SHALL rise max(1,k)+1 cycles after the accept edge, where k is the number of shift steps (k<=26).
REQ-013 result_mant SHALL equal mant[25:0] after normalisation; result_sign SHALL equal the captured in_sign.

Reset
REQ-014 On rst_n=0, regardless of state, SHALL set: FSM=IDLE, in_ready=1, out_valid=0, result_mant=0, result_exp=0, result_sign=0, overflow=0, norm_zero=0.
REQ-015 Reset asserted mid-NORM SHALL discard the operation; the first post-reset accept SHALL behave as from a clean start.

Configuration
REQ-016 With FP_NORM_LZC_EN defined: NORM SHALL complete any normalisation in exactly one cycle using a leading-zero count and barrel shift, clamped by REQ-007, so out_valid rises 2 cycles after accept.
REQ-017 Without FP_NORM_LZC_EN: the iterative behaviour of REQ-006/REQ-012 SHALL apply; results SHALL be bit-identical to the REQ-016 results.

Structure
REQ-018 Package fpu_pkg SHALL hold: mantissa widths (28/26), EXP_MAX=8'd255, the FSM state enum, and GRS bit index constants.
REQ-019 With FP_NORM_LZC_EN defined, SHALL instantiate sub-module fp_lzc28 (28-bit leading-zero counter, 5-bit count, all-zero flag).

Verification
REQ-020 in_mant=28'h4000000, exp=127 -> one NORM cycle; result_mant=0, result_exp=127; out_valid 2 cycles after accept.
REQ-021 in_mant=28'h8000003, exp=127 -> result_exp=128, result_mant=26'h0000001 (sticky kept).
REQ-022 in_mant=28'h0000008, exp=100 -> 23 left shifts; result_exp=77, result_mant=0; latency 24 (iterative) or 2 (LZC).
REQ-023 in_mant=28'h8000000, exp=254 -> overflow=1, result_exp=255, result_mant=0.
REQ-024 in_mant=28'h0100000, exp=3 -> stops at exp 1 with mant[26]=0; result_exp=0, result_mant=26'h0400000 after 2 shifts; also in_mant=0 -> norm_zero=1.
REQ-025 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; assert rst_n=0 mid-NORM -> all outputs at reset values next cycle.
